// File: rtl/spi_wr_pkg.sv
// spi_wr_pkg: shared widths and the buffered write-entry type
// used by the SPI write-command buffer and its storage array.
package spi_wr_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    localparam int ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/spi_wr_buffer_mem.sv
// spi_wr_buffer_mem: DEPTH x wr_entry_t storage, one write port,
// one asynchronous read port; no reset on the contents.
module spi_wr_buffer_mem
    import spi_wr_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [ENTRY_W-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [ENTRY_W-1:0]         rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_wr_buffer.sv
// spi_wr_buffer: DEPTH-entry show-ahead FIFO between the SPI write receiver
// and the bus. Define SPI_WR_BUFFER_STATS_EN to add accept/drop counters.
module spi_wr_buffer
    import spi_wr_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_address_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [ADDR_W-1:0]        m_address_o,
    output logic [DATA_W-1:0]        m_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    input  logic                     ovf_clr_i
`ifdef SPI_WR_BUFFER_STATS_EN
    ,
    output logic [31:0]              accepted_cnt_o,
    output logic [15:0]              dropped_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] mem_cnt;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    wr_entry_t        head_q, head_d;
    wr_entry_t        wr_entry, rd_entry;
    logic             push, pop, drop, load, mem_we;

    assign wr_entry = '{addr: wr_address_i, data: wr_data_i};
    assign pop      = valid_q & m_ready_i;
    assign push     = wr_en_i & ((level_q < LVL_W'(DEPTH)) | pop);
    assign drop     = wr_en_i & ~push;
    assign load     = ~valid_q | pop;
    // level_o counts the head register too; the array holds the rest.
    assign mem_cnt  = level_q - LVL_W'(valid_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        head_d   = head_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        ovf_d    = drop | (ovf_q & ~ovf_clr_i);
        mem_we   = push;
        if (load) begin
            if (mem_cnt != '0) begin
                head_d   = rd_entry;
                rd_ptr_d = rd_ptr_q + 1'b1;
                valid_d  = 1'b1;
            end else if (push) begin
                head_d   = wr_entry;
                valid_d  = 1'b1;
                mem_we   = 1'b0;
            end else begin
                valid_d  = 1'b0;
            end
        end
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            head_q   <= head_d;
        end
    end

    spi_wr_buffer_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign m_valid_o   = valid_q;
    assign m_address_o = head_q.addr;
    assign m_data_o    = head_q.data;
    assign level_o     = level_q;
    assign overflow_o  = ovf_q;

`ifdef SPI_WR_BUFFER_STATS_EN
    logic [31:0] accepted_cnt_q, accepted_cnt_d;
    logic [15:0] dropped_cnt_q, dropped_cnt_d;

    // A clear coinciding with a drop restarts the drop count at one.
    always_comb begin
        accepted_cnt_d = accepted_cnt_q;
        if (push && accepted_cnt_q != '1) begin
            accepted_cnt_d = accepted_cnt_q + 32'd1;
        end
        dropped_cnt_d = ovf_clr_i ? '0 : dropped_cnt_q;
        if (drop && dropped_cnt_d != '1) begin
            dropped_cnt_d = dropped_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            accepted_cnt_q <= '0;
            dropped_cnt_q  <= '0;
        end else begin
            accepted_cnt_q <= accepted_cnt_d;
            dropped_cnt_q  <= dropped_cnt_d;
        end
    end

    assign accepted_cnt_o = accepted_cnt_q;
    assign dropped_cnt_o  = dropped_cnt_q;
`endif

endmodule

// File: tb/tb_spi_wr_buffer.sv
// tb_spi_wr_buffer: directed vector table plus hand-written sequences
// for random-ready draining and asynchronous reset.
module tb_spi_wr_buffer;
    import spi_wr_pkg::*;

    logic        clk_i;
    logic        arst_i;
    logic        wr_en_i;
    logic [23:0] wr_address_i;
    logic [31:0] wr_data_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [23:0] m_address_o;
    logic [31:0] m_data_o;
    logic [3:0]  level_o;
    logic        overflow_o;
    logic        ovf_clr_i;
`ifdef SPI_WR_BUFFER_STATS_EN
    logic [31:0] accepted_cnt_o;
    logic [15:0] dropped_cnt_o;
`endif

    spi_wr_buffer #(
        .DEPTH (8)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .wr_en_i      (wr_en_i),
        .wr_address_i (wr_address_i),
        .wr_data_i    (wr_data_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_address_o  (m_address_o),
        .m_data_o     (m_data_o),
        .level_o      (level_o),
        .overflow_o   (overflow_o),
        .ovf_clr_i    (ovf_clr_i)
`ifdef SPI_WR_BUFFER_STATS_EN
        ,
        .accepted_cnt_o (accepted_cnt_o),
        .dropped_cnt_o  (dropped_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [23:0] a;
        logic [31:0] d;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic        cad;
        logic [23:0] ea;
        logic [31:0] ed;
        logic [3:0]  el;
        logic        eo;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];
    wr_entry_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic wr, input logic [23:0] a, input logic [31:0] d,
        input logic rdy, input logic clr, input logic ev,
        input logic cad, input logic [23:0] ea, input logic [31:0] ed,
        input logic [3:0] el, input logic eo);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.cad = cad; v.ea = ea; v.ed = ed;
        v.el = el; v.eo = eo;
        return v;
    endfunction

    initial begin
        int sent;
        int cyc;
        logic rdy;
        logic do_wr;
        logic [7:0] j;
        wr_entry_t e;

        arst_i = 1'b1;
        wr_en_i = 1'b0;
        wr_address_i = '0;
        wr_data_i = '0;
        m_ready_i = 1'b0;
        ovf_clr_i = 1'b0;

        // single write with ready high, then ready on an empty buffer
        tbl.push_back(mk(1, 24'h00FF00, 32'hFF00FF00, 1, 0,
                         1, 1, 24'h00FF00, 32'hFF00FF00, 4'd1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0));
        // fill with ready low: A=i, D=~i
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(1, 24'(i), ~32'(i), 0, 0,
                             1, 1, 24'h0, 32'hFFFFFFFF, 4'(i + 1), 0));
        end
        // overflow, clear, drop-with-clear, clear again
        tbl.push_back(mk(1, 24'h99, 32'h99, 0, 0,
                         1, 1, 24'h0, 32'hFFFFFFFF, 4'd8, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1,
                         1, 1, 24'h0, 32'hFFFFFFFF, 4'd8, 0));
        tbl.push_back(mk(1, 24'h77, 32'h77, 0, 1,
                         1, 1, 24'h0, 32'hFFFFFFFF, 4'd8, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1,
                         1, 1, 24'h0, 32'hFFFFFFFF, 4'd8, 0));
        // full: write and pop together, then drain in order
        tbl.push_back(mk(1, 24'hAA, 32'h55, 1, 0,
                         1, 1, 24'h1, 32'hFFFFFFFE, 4'd8, 0));
        for (int k = 1; k < 7; k++) begin
            tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 24'(k + 1),
                             ~32'(k + 1), 4'(8 - k), 0));
        end
        tbl.push_back(mk(0, 0, 0, 1, 0,
                         1, 1, 24'hAA, 32'h55, 4'd1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0));

        repeat (2) @(posedge clk_i);
        #2 arst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("rst valid", 64'(m_valid_o), 64'(0));
        chk("rst level", 64'(level_o), 64'(0));
        chk("rst addr", 64'(m_address_o), 64'(0));
        chk("rst data", 64'(m_data_o), 64'(0));
        chk("rst ovf", 64'(overflow_o), 64'(0));

        foreach (tbl[i]) begin
            wr_en_i = tbl[i].wr;
            wr_address_i = tbl[i].a;
            wr_data_i = tbl[i].d;
            m_ready_i = tbl[i].rdy;
            ovf_clr_i = tbl[i].clr;
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d valid", i), 64'(m_valid_o), 64'(tbl[i].ev));
            chk($sformatf("v%0d level", i), 64'(level_o), 64'(tbl[i].el));
            chk($sformatf("v%0d ovf", i), 64'(overflow_o), 64'(tbl[i].eo));
            if (tbl[i].cad) begin
                chk($sformatf("v%0d addr", i), 64'(m_address_o),
                    64'(tbl[i].ea));
                chk($sformatf("v%0d data", i), 64'(m_data_o),
                    64'(tbl[i].ed));
            end
        end
        wr_en_i = 1'b0;
        m_ready_i = 1'b0;
        ovf_clr_i = 1'b0;

        // random ready, 256 frames, scoreboard
        sent = 0;
        cyc = 0;
        while ((sent < 256 || sb.size() != 0) && cyc < 4000) begin
            rdy = 1'($urandom_range(0, 1));
            do_wr = (sent < 256) && (level_o < 4'd8) &&
                    ($urandom_range(0, 3) != 0);
            m_ready_i = rdy;
            wr_en_i = do_wr;
            if (m_valid_o && rdy) begin
                if (sb.size() == 0) begin
                    chk("sb spurious valid", 64'(m_valid_o), 64'(0));
                end else begin
                    chk("sb addr", 64'(m_address_o), 64'(sb[0].addr));
                    chk("sb data", 64'(m_data_o), 64'(sb[0].data));
                    void'(sb.pop_front());
                end
            end
            if (do_wr) begin
                j = 8'(sent);
                e.addr = {j, ~j, j};
                e.data = {~j, j, ~j, j};
                wr_address_i = e.addr;
                wr_data_i = e.data;
                sb.push_back(e);
                sent++;
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        wr_en_i = 1'b0;
        m_ready_i = 1'b0;
        if (cyc >= 4000) begin
            checks++;
            errors++;
            $display("FAIL sb timeout: sent %0d left %0d", sent, sb.size());
        end
        chk("sb ovf", 64'(overflow_o), 64'(0));
        chk("sb level", 64'(level_o), 64'(0));

        // reset mid-drain with five entries
        for (int i = 0; i < 5; i++) begin
            wr_en_i = 1'b1;
            wr_address_i = 24'(8'h10 + i);
            wr_data_i = 32'(8'h20 + i);
            @(posedge clk_i);
            #1;
        end
        wr_en_i = 1'b0;
        chk("pre-rst level", 64'(level_o), 64'(5));
        #2 arst_i = 1'b1;
        #1;
        chk("arst valid", 64'(m_valid_o), 64'(0));
        chk("arst level", 64'(level_o), 64'(0));
        @(negedge clk_i);
        arst_i = 1'b0;
        wr_en_i = 1'b1;
        wr_address_i = 24'h123456;
        wr_data_i = 32'hCAFEF00D;
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
        chk("post-rst valid", 64'(m_valid_o), 64'(1));
        chk("post-rst addr", 64'(m_address_o), 64'(24'h123456));
        chk("post-rst data", 64'(m_data_o), 64'(32'hCAFEF00D));
        chk("post-rst level", 64'(level_o), 64'(1));
`ifdef SPI_WR_BUFFER_STATS_EN
        chk("stat accepted", 64'(accepted_cnt_o), 64'(1));
        chk("stat dropped", 64'(dropped_cnt_o), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
